mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter between the instruction cache and the
// data cache in front of a single shared RAM port.
//
// Data requests normally win. Once STARVE_MAX consecutive data transfers
// have completed while an instruction fetch was waiting, the fetch wins
// the next arbitration.
//
// Ports:
//   CLK, nRST                          clock, asynchronous active-low reset
//   iREN, iaddr / iwait, iload         instruction-cache side
//   dREN, dWEN, daddr, dstore /
//     dwait, dload                     data-cache side
//   ramREN, ramWEN, ramaddr, ramstore,
//     ramload, ramstate                shared RAM port
//   ram_fault                          sticky flag for a grant that waited TIMEOUT cycles
//   dstreak                            consecutive data grants made while a fetch waited (debug)
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_fault,
  output logic [2:0]  dstreak
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [2:0] STARVE_C = 3'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t           state;
  logic [2:0]       streak;
  logic [CNT_W-1:0] tcount;
  logic             fault;

  logic req_d;
  logic access;
  logic i_done;
  logic d_done;
  logic starve;
  logic in_grant;
  logic withdrawn;

  assign req_d  = dREN | dWEN;
  assign access = (ramstate == RAM_ACCESS);
  // A transfer only completes if its requester is still asking for it;
  // ACCESS that coincides with a withdrawal is not a completion.
  assign i_done = (state == GNT_I) && iREN && access;
  assign d_done = (state == GNT_D) && req_d && access;
  assign starve = iREN && (streak == STARVE_C);
  assign in_grant  = (state == GNT_I) || (state == GNT_D);
  assign withdrawn = ((state == GNT_I) && !iREN) || ((state == GNT_D) && !req_d);

  assign ram_fault = fault;
  assign dstreak   = streak;

  // RAM port and wait/load outputs follow the live request inputs so that
  // a completion shows up in the same cycle as ACCESS.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = ~i_done;
    dwait    = ~d_done;
    iload    = i_done ? ramload : '0;
    dload    = d_done ? ramload : '0;
    case (state)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      GNT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
      tcount <= '0;
      fault  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_d && !starve) state <= GNT_D;
          else if (iREN)        state <= GNT_I;
        end
        GNT_I, GNT_D: begin
          if (access || withdrawn) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (i_done)
        streak <= '0;
      else if (d_done && iREN && (streak != STARVE_C))
        streak <= streak + 3'd1;
      else if ((state == IDLE) && !iREN)
        streak <= '0;

      // Timeout only flags the fault; the grant keeps waiting for ACCESS.
      if (in_grant && !access && !withdrawn) begin
        if (tcount != TIMEOUT_C) tcount <= tcount + 1'b1;
        if (tcount == TIMEOUT_C - 1'b1) fault <= 1'b1;
      end else begin
        tcount <= '0;
      end
    end
  end

endmodule
